// File: rtl/calcula_nota.sv
// ============================================================================
//  Module   : calcula_nota
//  Purpose  : Quiz scoring engine feeding the 7-segment grade decoder.
//             Optional input debounce filter enabled by macro DEBOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calcula_nota #(
  parameter int unsigned NUM_Q      = 10,
  parameter logic [19:0] GABARITO   = 20'b01_00_11_10_01_00_11_10_01_00,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicia,
  input  logic       confirma,
  input  logic [1:0] resposta,
  output logic [3:0] questao,
  output logic [3:0] nota,
  output logic       fim
);

  localparam logic [1:0] c_ST_OCIOSO   = 2'd0;
  localparam logic [1:0] c_ST_RESPONDE = 2'd1;
  localparam logic [1:0] c_ST_FIM      = 2'd2;

  localparam logic [3:0] c_LAST_Q = 4'(NUM_Q - 1);
  localparam logic [6:0] c_NQ     = 7'(NUM_Q);
  localparam logic [3:0] c_BLANK  = 4'hF;

  // --------------------------------------------------------------------------
  // Input synchronisers: bit 0 = inicia, bit 1 = confirma
  // --------------------------------------------------------------------------
  logic [1:0] btn_s1_q;
  logic [1:0] btn_s2_q;
  logic [1:0] resp_s1_q;
  logic [1:0] resp_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= 2'b00;
      btn_s2_q  <= 2'b00;
      resp_s1_q <= 2'b00;
      resp_s2_q <= 2'b00;
    end else begin
      btn_s1_q  <= {confirma, inicia};
      btn_s2_q  <= btn_s1_q;
      resp_s1_q <= resposta;
      resp_s2_q <= resp_s1_q;
    end
  end

  logic [1:0] w_btn_lvl;

`ifdef DEBOUNCE_EN
  localparam int unsigned c_CNT_W = $clog2(DEB_CYCLES + 1);

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic               filt_q;
    logic [c_CNT_W-1:0] cnt_q;

    // Filtered level flips only after DEB_CYCLES consecutive disagreeing clocks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (btn_s2_q[g] != filt_q) begin
        if (cnt_q == c_CNT_W'(DEB_CYCLES - 1)) begin
          filt_q <= btn_s2_q[g];
          cnt_q  <= '0;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end

    assign w_btn_lvl[g] = filt_q;
  end
`else
  assign w_btn_lvl = btn_s2_q;
`endif

  // --------------------------------------------------------------------------
  // Rising-edge detect: one pulse per press
  // --------------------------------------------------------------------------
  logic [1:0] btn_edge_q;
  logic       w_ini_pulse;
  logic       w_conf_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_edge_q <= 2'b00;
    end else begin
      btn_edge_q <= w_btn_lvl;
    end
  end

  assign w_ini_pulse  = w_btn_lvl[0] & ~btn_edge_q[0];
  assign w_conf_pulse = w_btn_lvl[1] & ~btn_edge_q[1];

  // --------------------------------------------------------------------------
  // Scoring datapath
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [3:0] questao_q, questao_d;
  logic [3:0] acertos_q, acertos_d;
  logic [3:0] nota_q, nota_d;
  logic       fim_q, fim_d;

  logic [1:0] w_key;
  logic       w_hit;
  logic [3:0] w_final;
  logic [6:0] w_prod;
  logic [3:0] w_grade;
  logic       w_last;

  assign w_key   = GABARITO[{questao_q, 1'b0} +: 2];
  assign w_hit   = (resp_s2_q == w_key);
  assign w_final = acertos_q + {3'b000, w_hit};
  assign w_prod  = 7'(w_final) * 7'd10;
  assign w_grade = 4'(w_prod / c_NQ);
  assign w_last  = (questao_q == c_LAST_Q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_OCIOSO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inicia always takes priority over confirma
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_OCIOSO: begin
        if (w_ini_pulse) state_d = c_ST_RESPONDE;
      end
      c_ST_RESPONDE: begin
        if (w_ini_pulse)                 state_d = c_ST_RESPONDE;
        else if (w_conf_pulse && w_last) state_d = c_ST_FIM;
      end
      c_ST_FIM: begin
        if (w_ini_pulse) state_d = c_ST_RESPONDE;
      end
      default: state_d = c_ST_OCIOSO;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    questao_d = questao_q;
    acertos_d = acertos_q;
    nota_d    = nota_q;
    fim_d     = fim_q;
    case (state_q)
      c_ST_OCIOSO, c_ST_FIM: begin
        if (w_ini_pulse) begin
          questao_d = 4'd0;
          acertos_d = 4'd0;
          nota_d    = c_BLANK;
          fim_d     = 1'b0;
        end
      end
      c_ST_RESPONDE: begin
        if (w_ini_pulse) begin
          questao_d = 4'd0;
          acertos_d = 4'd0;
          nota_d    = c_BLANK;
          fim_d     = 1'b0;
        end else if (w_conf_pulse) begin
          acertos_d = w_final;
          if (w_last) begin
            nota_d = w_grade;
            fim_d  = 1'b1;
          end else begin
            questao_d = questao_q + 4'd1;
          end
        end
      end
      default: begin
        questao_d = 4'd0;
        acertos_d = 4'd0;
        nota_d    = c_BLANK;
        fim_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      questao_q <= 4'd0;
      acertos_q <= 4'd0;
      nota_q    <= c_BLANK;
      fim_q     <= 1'b0;
    end else begin
      questao_q <= questao_d;
      acertos_q <= acertos_d;
      nota_q    <= nota_d;
      fim_q     <= fim_d;
    end
  end

  assign questao = questao_q;
  assign nota    = nota_q;
  assign fim     = fim_q;

endmodule

`default_nettype wire

// File: tb/tb_calcula_nota.sv
// ============================================================================
//  Module   : tb_calcula_nota
//  Purpose  : Directed self-checking bench for calcula_nota (default build).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calcula_nota;

  logic       clk;
  logic       rst_n;
  logic       inicia;
  logic       confirma;
  logic [1:0] resposta;
  logic [3:0] questao, nota;
  logic       fim;
  logic [3:0] questao4, nota4;
  logic       fim4;

  int tests_run = 0;
  int tests_failed = 0;

  calcula_nota u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inicia   (inicia),
    .confirma (confirma),
    .resposta (resposta),
    .questao  (questao),
    .nota     (nota),
    .fim      (fim)
  );

  calcula_nota #(.NUM_Q(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .inicia   (inicia),
    .confirma (confirma),
    .resposta (resposta),
    .questao  (questao4),
    .nota     (nota4),
    .fim      (fim4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    inicia   = 1'b0;
    confirma = 1'b0;
    resposta = 2'd0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic pulse_inicia;
    inicia = 1'b1;
    tick(2);
    inicia = 1'b0;
    tick(3);
  endtask

  task automatic answer(input logic [1:0] a);
    resposta = a;
    confirma = 1'b1;
    tick(2);
    confirma = 1'b0;
    tick(3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inicia = 1'b0; confirma = 1'b0; resposta = 2'd0;
    tick(2);
    tests_run++;
    if (questao !== 4'd0 || nota !== 4'hF || fim !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got q=%0d nota=%h fim=%b expected q=0 nota=f fim=0", questao, nota, fim);
    end
    rst_n = 1'b1;
    tick(3);
    answer(2'd0);
    tests_run++;
    if (questao !== 4'd0 || fim !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignores_confirma: got q=%0d fim=%b expected q=0 fim=0", questao, fim);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    pulse_inicia();
    for (int i = 0; i < 4; i++) answer(2'(i));
    tests_run++;
    if (questao !== 4'd4) begin
      tests_failed++;
      $display("FAIL midquiz_questao: got %0d expected 4", questao);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (questao !== 4'd0 || nota !== 4'hF || fim !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got q=%0d nota=%h fim=%b expected q=0 nota=f fim=0", questao, nota, fim);
    end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    answer(2'd0);
    tests_run++;
    if (questao !== 4'd0 || nota !== 4'hF || fim !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got q=%0d nota=%h fim=%b expected q=0 nota=f fim=0", questao, nota, fim);
    end
  endtask

  task automatic test_all_correct;
    do_reset();
    pulse_inicia();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (questao !== 4'(i) || nota !== 4'hF || fim !== 1'b0) begin
        tests_failed++;
        $display("FAIL step_q%0d: got q=%0d nota=%h fim=%b expected q=%0d nota=f fim=0", i, questao, nota, fim, i);
      end
      answer(2'(i));
    end
    tests_run++;
    if (fim !== 1'b1 || nota !== 4'd10 || questao !== 4'd9) begin
      tests_failed++;
      $display("FAIL all_correct: got q=%0d nota=%0d fim=%b expected q=9 nota=10 fim=1", questao, nota, fim);
    end
    answer(2'd1);
    tests_run++;
    if (fim !== 1'b1 || nota !== 4'd10 || questao !== 4'd9) begin
      tests_failed++;
      $display("FAIL fim_ignores_confirma: got q=%0d nota=%0d fim=%b expected q=9 nota=10 fim=1", questao, nota, fim);
    end
    pulse_inicia();
    tests_run++;
    if (fim !== 1'b0 || nota !== 4'hF || questao !== 4'd0) begin
      tests_failed++;
      $display("FAIL restart_from_fim: got q=%0d nota=%h fim=%b expected q=0 nota=f fim=0", questao, nota, fim);
    end
  endtask

  task automatic test_seven_correct;
    do_reset();
    pulse_inicia();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        tests_run++;
        if (nota !== 4'hF || fim !== 1'b0) begin
          tests_failed++;
          $display("FAIL before_last: got nota=%h fim=%b expected nota=f fim=0", nota, fim);
        end
      end
      if (i == 2 || i == 5 || i == 8) answer(2'(i + 1));
      else                            answer(2'(i));
    end
    tests_run++;
    if (nota !== 4'd7 || fim !== 1'b1) begin
      tests_failed++;
      $display("FAIL seven_correct: got nota=%0d fim=%b expected nota=7 fim=1", nota, fim);
    end
  endtask

  task automatic test_hold_confirma;
    do_reset();
    pulse_inicia();
    resposta = 2'd0;
    confirma = 1'b1;
    tick(2);
    tests_run++;
    if (questao !== 4'd0) begin
      tests_failed++;
      $display("FAIL hold_latency_early: got q=%0d expected 0", questao);
    end
    tick(1);
    tests_run++;
    if (questao !== 4'd1) begin
      tests_failed++;
      $display("FAIL hold_latency_edge3: got q=%0d expected 1", questao);
    end
    tick(17);
    confirma = 1'b0;
    tick(3);
    tests_run++;
    if (questao !== 4'd1) begin
      tests_failed++;
      $display("FAIL hold_single_step: got q=%0d expected 1", questao);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    pulse_inicia();
    for (int i = 0; i < 5; i++) answer(2'(i));
    tests_run++;
    if (questao !== 4'd5) begin
      tests_failed++;
      $display("FAIL simul_setup: got q=%0d expected 5", questao);
    end
    resposta = 2'd1;
    inicia   = 1'b1;
    confirma = 1'b1;
    tick(2);
    inicia   = 1'b0;
    confirma = 1'b0;
    tick(3);
    tests_run++;
    if (questao !== 4'd0 || nota !== 4'hF || fim !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_inicia_wins: got q=%0d nota=%h fim=%b expected q=0 nota=f fim=0", questao, nota, fim);
    end
    for (int i = 0; i < 10; i++) answer(2'(i));
    tests_run++;
    if (nota !== 4'd10 || fim !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_then_all_correct: got nota=%0d fim=%b expected nota=10 fim=1", nota, fim);
    end
  endtask

  task automatic test_numq4;
    do_reset();
    pulse_inicia();
    answer(2'd0); answer(2'd1); answer(2'd3); answer(2'd3);
    tests_run++;
    if (nota4 !== 4'd7 || fim4 !== 1'b1 || questao4 !== 4'd3) begin
      tests_failed++;
      $display("FAIL numq4_three_correct: got q=%0d nota=%0d fim=%b expected q=3 nota=7 fim=1", questao4, nota4, fim4);
    end
    tests_run++;
    if (fim !== 1'b0 || questao !== 4'd4) begin
      tests_failed++;
      $display("FAIL numq10_midway: got q=%0d fim=%b expected q=4 fim=0", questao, fim);
    end
    pulse_inicia();
    answer(2'd0); answer(2'd0); answer(2'd0); answer(2'd0);
    tests_run++;
    if (nota4 !== 4'd2 || fim4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL numq4_one_correct: got nota=%0d fim=%b expected nota=2 fim=1", nota4, fim4);
    end
    pulse_inicia();
    answer(2'd1); answer(2'd2); answer(2'd3); answer(2'd0);
    tests_run++;
    if (nota4 !== 4'd0 || fim4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL numq4_none_correct: got nota=%0d fim=%b expected nota=0 fim=1", nota4, fim4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    inicia   = 1'b0;
    confirma = 1'b0;
    resposta = 2'd0;
    test_reset();
    test_async_reset();
    test_all_correct();
    test_seven_correct();
    test_hold_confirma();
    test_simultaneous();
    test_numq4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
